modbus_uart: RTL
================

// Module: modbus_uart
// PURPOSE
//  8N1 UART byte link for the ModBus ASCII interpreter: serialises bytes from it and deserialises line bytes to it.
//  Exposes the one-byte RxBuf/RxRdy/RxErr/Read_RxBuf and TxBuf/TxEmpty/Write_TxBuf handshake.
//  Sits between the board RS-232 pins and the interpreter; 16x oversampled receiver, single-buffered transmitter.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency
//  BAUD        19200       line rate, bits/s
//  OVERSAMPLE  16          sample ticks per bit (fixed 16; other values unsupported)
// PORTS
//  clk          in   1  system clock, all logic on rising edge
//  Reset        in   1  asynchronous, active-low reset (0 = reset)
//  RxD          in   1  serial input, idle high, asynchronous to clk
//  TxD          out  1  serial output, idle high
//  RxBuf        out  8  last received byte, valid while RxRdy=1
//  RxRdy        out  1  received byte waiting
//  RxErr        out  1  byte in RxBuf had framing error or overran an unread byte
//  Read_RxBuf   in   1  consumer acknowledge, 1-cycle pulse, clears RxRdy/RxErr
//  TxBuf        in   8  byte to send
//  Write_TxBuf  in   1  1-cycle strobe; latches TxBuf when TxEmpty=1
//  TxEmpty      out  1  transmitter idle, may accept a byte
// BEHAVIOUR
//  Reset (async assert, sync release through the flops): TxD=1, RxBuf=0, RxRdy=0, RxErr=0, TxEmpty=1, both FSMs IDLE, divider 0.
//  Tick: divider counts 0..DIV-1, DIV=round(CLK_HZ/(BAUD*16)); one-cycle tick at wrap; shared by RX and TX.
//  RX sync: RxD through 2 flops before use; all RX decisions use the synchronised value.
//  RX FSM: IDLE -> START on synced RxD=0.
//   START: on tick 8, RxD=0 -> DATA (bit phase reset); RxD=1 -> IDLE (glitch, nothing reported).
//   DATA: sample every 16 ticks from mid-start, 8 bits LSB first into shift reg -> STOP.
//   STOP: sample mid-stop. RxBuf<=shift, RxRdy<=1, RxErr<=(stop==0)|(RxRdy & !Read_RxBuf).
//    Stop=1 -> IDLE; stop=0 -> BREAK, then wait for RxD=1 -> IDLE.
//  Read_RxBuf=1 at an edge clears RxRdy and RxErr at that edge, so RxRdy=0 in the next cycle.
//   The consumer samples RxRdy every 2nd cycle and relies on this.
//  Completion and Read_RxBuf at the same edge: the new byte wins; RxRdy=1, RxErr=framing only (no overrun).
//  Overrun: a new byte completes while RxRdy=1 and no ack -> RxBuf overwritten, RxErr=1.
//  Read_RxBuf while RxRdy=0: no effect.
//  TX FSM: IDLE, START, DATA, STOP.
//   Write_TxBuf while TxEmpty=1: latch TxBuf, TxEmpty=0 next cycle.
//    Start bit begins at the next tick: 16 ticks low, 8 data bits LSB first of 16 ticks each, then 16 ticks high.
//   TxEmpty returns to 1 the cycle after the stop bit's 16th tick, so one frame is 160 ticks.
//   Write_TxBuf while TxEmpty=0: ignored, no corruption.
//  Back-to-back frames: a write in the first TxEmpty=1 cycle gives no extra idle beyond tick alignment (<=1 tick).
//  Reset mid-frame: TxD returns to 1 immediately (asynchronously); a partial RX byte is discarded.
// STRUCTURE
//  Shared package/include: OVERSAMPLE, MODBUS_START(58), CR(13), LF(10) constants, shared with the interpreter.
//  Sub-module uart_baud_gen: parameterised divider producing the tick. RX and TX FSMs live in this module.
//  Both FSMs use a 4-bit tick counter and a 3-bit bit index. Target size 150-250 lines.
// TESTING  (CLK_HZ=16*BAUD*4, so DIV=4, to keep sims short)
//  1. Line frame 0x3A, good stop -> RxRdy=1, RxBuf=0x3A, RxErr=0; Read_RxBuf pulse -> RxRdy=0 next cycle.
//  2. Frame 0x55 with stop=0 -> RxRdy=1, RxErr=1; line held low -> no new byte until RxD=1 and next start.
//  3. Bytes 0x41 then 0x42 without ack -> RxBuf=0x42, RxErr=1; ack at completion edge -> RxErr=0.
//  4. RxD low pulse of 5 ticks -> no RxRdy, RX back in IDLE.
//  5. Write_TxBuf 0x0D while TxEmpty=1 -> TxD bits 0,1,0,1,1,0,0,0,0,1, each 16 ticks; TxEmpty=0 for 160 ticks.
//     Second write during the frame is ignored.
//  6. Reset=0 mid-TX and mid-RX -> TxD=1, TxEmpty=1, RxRdy=0 at once; a clean frame after release is received correctly.

Source files
------------

// File: rtl/modbus_uart_pkg.sv
// Shared constants and types for the ModBus ASCII UART link and its interpreter.
package modbus_uart_pkg;

  localparam int unsigned OVERSAMPLE   = 16;
  localparam logic [7:0]  MODBUS_START = 8'd58;
  localparam logic [7:0]  CR           = 8'd13;
  localparam logic [7:0]  LF           = 8'd10;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Rounded clock divide for one oversample tick.
  function automatic int unsigned baud_div(input int unsigned clk_hz,
                                           input int unsigned baud,
                                           input int unsigned osr);
    return (clk_hz + (baud * osr) / 2) / (baud * osr);
  endfunction

endpackage

// File: rtl/modbus_uart_baud_gen.sv
// Free-running divider: one-cycle tick every DIV clocks, shared by RX and TX.
module uart_baud_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  always_comb begin
    wrap  = (cnt_q == CW'(DIV - 1));
    cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = wrap;

endmodule

// File: rtl/modbus_uart.sv
// 8N1 UART byte link for the ModBus ASCII interpreter: 16x oversampled RX,
// single-buffered TX, one-byte RxBuf/TxBuf handshakes.
module modbus_uart
  import modbus_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 19200,
  parameter int unsigned OVERSAMPLE = modbus_uart_pkg::OVERSAMPLE
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       RxD,
  output logic       TxD,
  output logic [7:0] RxBuf,
  output logic       RxRdy,
  output logic       RxErr,
  input  logic       Read_RxBuf,
  input  logic [7:0] TxBuf,
  input  logic       Write_TxBuf,
  output logic       TxEmpty
);

  localparam int unsigned DIV = baud_div(CLK_HZ, BAUD, OVERSAMPLE);

  logic tick;

  uart_baud_gen #(.DIV(DIV)) u_baud (
    .clk   (clk),
    .rst_n (Reset),
    .tick_o(tick)
  );

  logic [1:0] rx_sync_q;
  logic       rx_s;
  rx_state_e  rx_state_q, rx_state_d;
  logic [3:0] rx_tick_q, rx_tick_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_buf_q, rx_buf_d;
  logic       rx_rdy_q, rx_rdy_d;
  logic       rx_err_q, rx_err_d;

  assign rx_s = rx_sync_q[1];

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      rx_sync_q  <= '1;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_buf_q   <= '0;
      rx_rdy_q   <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], RxD};
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_buf_q   <= rx_buf_d;
      rx_rdy_q   <= rx_rdy_d;
      rx_err_q   <= rx_err_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_buf_d   = rx_buf_q;
    rx_rdy_d   = rx_rdy_q;
    rx_err_d   = rx_err_q;
    if (Read_RxBuf) begin
      rx_rdy_d = 1'b0;
      rx_err_d = 1'b0;
    end
    unique case (rx_state_q)
      RX_IDLE: if (!rx_s) begin
        rx_state_d = RX_START;
        rx_tick_d  = '0;
      end
      RX_START: if (tick) begin
        if (rx_tick_q == 4'd7) begin
          rx_tick_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_tick_d = rx_tick_q + 4'd1;
        end
      end
      RX_DATA: if (tick) begin
        rx_tick_d = rx_tick_q + 4'd1;
        if (rx_tick_q == 4'd15) begin
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: if (tick) begin
        rx_tick_d = rx_tick_q + 4'd1;
        if (rx_tick_q == 4'd15) begin
          // A completing byte overrides a same-edge acknowledge.
          rx_buf_d   = rx_shift_q;
          rx_rdy_d   = 1'b1;
          rx_err_d   = !rx_s || (rx_rdy_q && !Read_RxBuf);
          rx_state_d = rx_s ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: if (rx_s) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  tx_state_e  tx_state_q, tx_state_d;
  logic [3:0] tx_tick_q, tx_tick_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       txd_q, txd_d;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    unique case (tx_state_q)
      TX_IDLE: if (Write_TxBuf) begin
        tx_shift_d = TxBuf;
        tx_state_d = TX_START;
      end
      TX_START: if (tick) begin
        // Line still high here means the start bit has not begun yet.
        if (txd_q) begin
          txd_d     = 1'b0;
          tx_tick_d = '0;
        end else begin
          tx_tick_d = tx_tick_q + 4'd1;
          if (tx_tick_q == 4'd15) begin
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = '0;
            tx_state_d = TX_DATA;
          end
        end
      end
      TX_DATA: if (tick) begin
        tx_tick_d = tx_tick_q + 4'd1;
        if (tx_tick_q == 4'd15) begin
          if (tx_bit_q == 3'd7) begin
            txd_d      = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_bit_d   = tx_bit_q + 3'd1;
          end
        end
      end
      TX_STOP: if (tick) begin
        tx_tick_d = tx_tick_q + 4'd1;
        if (tx_tick_q == 4'd15) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign TxD     = txd_q;
  assign TxEmpty = (tx_state_q == TX_IDLE);
  assign RxBuf   = rx_buf_q;
  assign RxRdy   = rx_rdy_q;
  assign RxErr   = rx_err_q;

endmodule
